id_stage: RTL and testbench

- Instruction-decode stage. Sits on the consumer end of the IF interface.
- Captures each 32-bit `instruction` that IF presents into an IF/ID register and drives IF's `PC_WE`, `PC_Src` and `offset` controls back to it.
- Resolves BEQ in ID and flushes the wrong-path fetch. Detects EX-stage load-use and branch hazards and stalls for them.
- Decodes fields into a registered ID/EX bundle.

---
 rtl/id_stage_if.sv | 25 ++
 rtl/id_stage.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Fetch <-> decode link for id_stage.
// The fetch stage presents the word at its current PC; the decode stage
// answers with the PC advance enable, the branch-select and the branch offset.
interface id_stage_if;
  logic [31:0] instruction;
  logic        PC_WE;
  logic        PC_Src;
  logic [15:0] offset;

  // Fetch side: owns the PC and drives the instruction word.
  modport master (
    output instruction,
    input  PC_WE,
    input  PC_Src,
    input  offset
  );

  // Decode side: consumes the instruction and steers the PC.
  modport slave (
    input  instruction,
    output PC_WE,
    output PC_Src,
    output offset
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage.
// Holds the IF/ID register, resolves BEQ in ID (one-cycle squash of the
// wrong-path fetch), stalls one cycle for EX load-use and branch-use hazards,
// and produces the registered ID/EX bundle. HALT stops the PC until reset.
// Optional macro ID_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module id_stage #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_HALT  = 6'h3F
) (
  input  logic        clk,
  input  logic        reset_n,
  id_stage_if.slave   fetch,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        ex_valid,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_dest,
  output logic [15:0] ex_imm,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        illegal,
  output logic        halted
`ifdef ID_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // IF/ID register
  logic        ifid_valid_reg;
  logic [31:0] ifid_instr_reg;

  // ID/EX register
  logic        ex_valid_reg;
  logic [5:0]  ex_op_reg;
  logic [5:0]  ex_funct_reg;
  logic [4:0]  ex_dest_reg;
  logic [15:0] ex_imm_reg;
  logic [31:0] ex_rs_val_reg;
  logic [31:0] ex_rt_val_reg;
  logic        ex_reg_write_reg;
  logic        ex_mem_read_reg;
  logic        ex_mem_write_reg;
  logic        illegal_reg;

  // IF/ID field split
  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm;
  logic [5:0]  id_funct;
  logic        unused_shamt;

  // Decode results
  logic [4:0]  dec_dest;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_known;

  // Hazard / control
  logic        uses_rt;
  logic        load_use;
  logic        branch_use;
  logic        stall;
  logic        issue;
  logic        branch_taken;
  logic        halt_hit;
  logic        pc_we;
  logic        pc_src;

  assign id_op        = ifid_instr_reg[31:26];
  assign id_rs        = ifid_instr_reg[25:21];
  assign id_rt        = ifid_instr_reg[20:16];
  assign id_rd        = ifid_instr_reg[15:11];
  assign id_imm       = ifid_instr_reg[15:0];
  assign id_funct     = ifid_instr_reg[5:0];
  // Shift amount is carried to EX inside ex_imm, never decoded here.
  assign unused_shamt = ^ifid_instr_reg[10:6];

  assign rs_addr = id_rs;
  assign rt_addr = id_rt;

  // Opcode decode: destination, write enables and legality.
  always_comb begin
    dec_dest      = 5'd0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_known     = 1'b1;
    case (id_op)
      OP_RTYPE: begin
        dec_dest      = id_rd;
        dec_reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec_dest      = id_rt;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_dest      = id_rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
      end
      OP_BEQ, OP_HALT: begin
        dec_dest = 5'd0;
      end
      default: begin
        dec_known = 1'b0;
      end
    endcase
    // r0 is hard-wired; a write to it (including the all-zero NOP) is dropped.
    if (dec_dest == 5'd0) begin
      dec_reg_write = 1'b0;
    end
  end

  // rt is a source operand only for R-type, BEQ and SW.
  assign uses_rt = (id_op == OP_RTYPE) | (id_op == OP_BEQ) | (id_op == OP_SW);

  assign load_use = ex_valid_reg & ex_mem_read_reg & (ex_dest_reg != 5'd0) &
                    ((id_rs == ex_dest_reg) | (uses_rt & (id_rt == ex_dest_reg)));

  // BEQ compares in ID, so any in-flight EX result it reads must land first.
  assign branch_use = (id_op == OP_BEQ) & ex_valid_reg & ex_reg_write_reg &
                      ((ex_dest_reg == id_rs) | (ex_dest_reg == id_rt));

  assign stall        = ifid_valid_reg & (load_use | branch_use);
  assign issue        = ifid_valid_reg & ~stall;
  assign branch_taken = issue & (id_op == OP_BEQ) & (rs_data == rt_data);
  assign halt_hit     = issue & (id_op == OP_HALT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and PC controls; only RUN ever moves the PC.
  always_comb begin
    state_next = state_reg;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        pc_we  = ~stall;
        pc_src = branch_taken;
        if (halt_hit) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  assign fetch.PC_WE  = pc_we;
  assign fetch.PC_Src = pc_src;
  assign fetch.offset = ifid_valid_reg ? id_imm : 16'd0;
  assign halted       = (state_reg == ST_HALT);

  // IF/ID capture; the word fetched alongside a taken branch is squashed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= 32'd0;
    end else if (pc_we) begin
      ifid_valid_reg <= ~pc_src;
      ifid_instr_reg <= fetch.instruction;
    end
  end

  // ID/EX capture; stalls, empty slots, illegal opcodes and halt idle become bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_reg     <= 1'b0;
      ex_op_reg        <= 6'd0;
      ex_funct_reg     <= 6'd0;
      ex_dest_reg      <= 5'd0;
      ex_imm_reg       <= 16'd0;
      ex_rs_val_reg    <= 32'd0;
      ex_rt_val_reg    <= 32'd0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_mem_write_reg <= 1'b0;
      illegal_reg      <= 1'b0;
    end else begin
      illegal_reg <= (state_reg == ST_RUN) & issue & ~dec_known;
      if ((state_reg == ST_RUN) && issue && dec_known) begin
        ex_valid_reg     <= 1'b1;
        ex_op_reg        <= id_op;
        ex_funct_reg     <= id_funct;
        ex_dest_reg      <= dec_dest;
        ex_imm_reg       <= id_imm;
        ex_rs_val_reg    <= rs_data;
        ex_rt_val_reg    <= rt_data;
        ex_reg_write_reg <= dec_reg_write;
        ex_mem_read_reg  <= dec_mem_read;
        ex_mem_write_reg <= dec_mem_write;
      end else begin
        ex_valid_reg     <= 1'b0;
        ex_op_reg        <= 6'd0;
        ex_funct_reg     <= 6'd0;
        ex_dest_reg      <= 5'd0;
        ex_imm_reg       <= 16'd0;
        ex_rs_val_reg    <= 32'd0;
        ex_rt_val_reg    <= 32'd0;
        ex_reg_write_reg <= 1'b0;
        ex_mem_read_reg  <= 1'b0;
        ex_mem_write_reg <= 1'b0;
      end
    end
  end

  assign ex_valid     = ex_valid_reg;
  assign ex_op        = ex_op_reg;
  assign ex_funct     = ex_funct_reg;
  assign ex_dest      = ex_dest_reg;
  assign ex_imm       = ex_imm_reg;
  assign ex_rs_val    = ex_rs_val_reg;
  assign ex_rt_val    = ex_rt_val_reg;
  assign ex_reg_write = ex_reg_write_reg;
  assign ex_mem_read  = ex_mem_read_reg;
  assign ex_mem_write = ex_mem_write_reg;
  assign illegal      = illegal_reg;

`ifdef ID_PERF_EN
  // Event 0 = a stall cycle, event 1 = a squash (taken branch).
  logic [1:0] perf_inc;
  assign perf_inc[0] = (state_reg == ST_RUN) & stall;
  assign perf_inc[1] = pc_src;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [15:0] cnt_reg;
      // Saturating event counter.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= 16'd0;
        end else if (perf_inc[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign stall_cnt = g_perf[0].cnt_reg;
  assign flush_cnt = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed program with literal
// expectations, an async reset taken mid-stall, then randomized episodes,
// all compared every cycle against a transaction-level model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_dest;
  logic [15:0] ex_imm;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        illegal;
  logic        halted;
`ifdef ID_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  id_stage_if fif ();

  id_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch        (fif),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_funct     (ex_funct),
    .ex_dest      (ex_dest),
    .ex_imm       (ex_imm),
    .ex_rs_val    (ex_rs_val),
    .ex_rt_val    (ex_rt_val),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .illegal      (illegal),
    .halted       (halted)
`ifdef ID_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic        rw;
    logic        mr;
    logic        mw;
  } exrec_t;

  localparam int S_BOOT = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  int          m_state;
  bit          m_ifv;
  logic [31:0] m_ifi;
  exrec_t      m_ex;
  bit          m_ill;
  int          m_stalls;
  int          m_flushes;
  bit          e_stall, e_taken, e_pcwe, e_pcsrc;

  function automatic bit known(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h3F};
  endfunction

  // What an instruction looks like once it sits in EX.
  function automatic exrec_t decode(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    exrec_t r;
    r       = '0;
    r.valid = 1'b1;
    r.op    = w[31:26];
    r.funct = w[5:0];
    r.imm   = w[15:0];
    r.rsv   = a;
    r.rtv   = b;
    case (w[31:26])
      6'h00: r.dest = w[15:11];
      6'h08: r.dest = w[20:16];
      6'h23: begin r.dest = w[20:16]; r.mr = 1'b1; end
      6'h2B: r.mw = 1'b1;
      default: r.dest = 5'd0;
    endcase
    r.rw = (r.dest != 5'd0);
    return r;
  endfunction

  task automatic model_reset();
    m_state   = S_BOOT;
    m_ifv     = 1'b0;
    m_ifi     = 32'd0;
    m_ex      = '0;
    m_ill     = 1'b0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic check_cycle();
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit lu, bu;
    op = m_ifi[31:26];
    rs = m_ifi[25:21];
    rt = m_ifi[20:16];
    lu = m_ex.valid && m_ex.mr && (m_ex.dest != 0) &&
         ((rs == m_ex.dest) || ((op == 6'h00 || op == 6'h04 || op == 6'h2B) && rt == m_ex.dest));
    bu = (op == 6'h04) && m_ex.valid && m_ex.rw && (m_ex.dest == rs || m_ex.dest == rt);
    e_stall = m_ifv && (lu || bu);
    e_taken = m_ifv && !e_stall && (op == 6'h04) && (rs_data == rt_data);
    e_pcwe  = (m_state == S_RUN) && !e_stall;
    e_pcsrc = (m_state == S_RUN) && e_taken;
    chk("rs_addr", rs_addr, rs);
    chk("rt_addr", rt_addr, rt);
    chk("PC_WE", fif.PC_WE, e_pcwe);
    chk("PC_Src", fif.PC_Src, e_pcsrc);
    chk("offset", fif.offset, m_ifv ? m_ifi[15:0] : 16'd0);
    chk("ex_valid", ex_valid, m_ex.valid);
    chk("ex_op", ex_op, m_ex.op);
    chk("ex_funct", ex_funct, m_ex.funct);
    chk("ex_dest", ex_dest, m_ex.dest);
    chk("ex_imm", ex_imm, m_ex.imm);
    chk("ex_rs_val", ex_rs_val, m_ex.rsv);
    chk("ex_rt_val", ex_rt_val, m_ex.rtv);
    chk("ex_reg_write", ex_reg_write, m_ex.rw);
    chk("ex_mem_read", ex_mem_read, m_ex.mr);
    chk("ex_mem_write", ex_mem_write, m_ex.mw);
    chk("illegal", illegal, m_ill);
    chk("halted", halted, m_state == S_HALT);
`ifdef ID_PERF_EN
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  // Advance the model across the coming clock edge.
  task automatic advance();
    exrec_t     nx;
    logic [5:0] op;
    bit         issue;
    nx    = '0;
    op    = m_ifi[31:26];
    issue = m_ifv && !e_stall;
    m_ill = 1'b0;
    if (m_state == S_RUN) begin
      if (issue && known(op)) nx = decode(m_ifi, rs_data, rt_data);
      m_ill = issue && !known(op);
      if (e_stall && m_stalls < 16'hFFFF) m_stalls++;
      if (e_pcsrc && m_flushes < 16'hFFFF) m_flushes++;
      if (e_pcwe) begin
        m_ifv = !e_taken;
        m_ifi = fif.instruction;
      end
      if (issue && op == 6'h3F) m_state = S_HALT;
    end else if (m_state == S_BOOT) begin
      m_state = S_RUN;
    end
    m_ex = nx;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [5:0] op;
    k = $urandom_range(0, 99);
    if      (k < 24) op = 6'h00;
    else if (k < 44) op = 6'h08;
    else if (k < 64) op = 6'h23;
    else if (k < 74) op = 6'h2B;
    else if (k < 92) op = 6'h04;
    else if (k < 95) op = ($urandom_range(0, 1) != 0) ? 6'h3E : 6'h01;
    else if (k < 96) op = 6'h3F;
    else return 32'd0;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  // Directed program, one entry per cycle starting with the BOOT cycle.
  localparam int ND = 13;
  logic [31:0] d_instr [ND];
  logic [31:0] d_rs    [ND];
  logic [31:0] d_rt    [ND];

  initial begin
    d_instr[0]  = 32'h20010005; d_instr[1]  = 32'h20010005; // ADDI r1,r0,5
    d_instr[2]  = 32'h8C220000;                             // LW r2,0(r1)
    d_instr[3]  = 32'h00421820; d_instr[4]  = 32'h00421820; // ADD r3,r2,r2
    d_instr[5]  = 32'h10000004;                             // BEQ r0,r0,+4
    d_instr[6]  = 32'h20010005;                             // wrong path
    d_instr[7]  = 32'h10000004;
    d_instr[8]  = 32'hF8000000;                             // opcode 3E
    d_instr[9]  = 32'hFC000000;                             // HALT
    d_instr[10] = 32'h00000000; d_instr[11] = 32'h00000000; d_instr[12] = 32'h00000000;
    for (int i = 0; i < ND; i++) begin
      d_rs[i] = 32'd0;
      d_rt[i] = 32'd0;
    end
    d_rs[8] = 32'd1;
    d_rt[8] = 32'd2;
  end

  initial begin
    reset_n         = 1'b0;
    fif.instruction = 32'd0;
    rs_data         = 32'd0;
    rt_data         = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_PC_WE", fif.PC_WE, 1'b0);
    chk("lit_reset_ex_valid", ex_valid, 1'b0);
    chk("lit_reset_offset", fif.offset, 16'd0);
    chk("lit_reset_halted", halted, 1'b0);
    reset_n = 1'b1;

    // Directed program with hand-computed expectations.
    for (int i = 0; i < ND; i++) begin
      fif.instruction = d_instr[i];
      rs_data         = d_rs[i];
      rt_data         = d_rt[i];
      @(negedge clk);
      check_cycle();
      case (i)
        0: chk("lit_boot_PC_WE", fif.PC_WE, 1'b0);
        1: begin chk("lit_run_PC_WE", fif.PC_WE, 1'b1); chk("lit_pre_ex_valid", ex_valid, 1'b0); end
        2: begin chk("lit_addi_rt_addr", rt_addr, 5'd1); chk("lit_addi_rs_addr", rs_addr, 5'd0); end
        3: begin
          chk("lit_addi_ex_valid", ex_valid, 1'b1);
          chk("lit_addi_ex_dest", ex_dest, 5'd1);
          chk("lit_addi_ex_imm", ex_imm, 16'h0005);
          chk("lit_addi_reg_write", ex_reg_write, 1'b1);
        end
        4: chk("lit_lu_stall_PC_WE", fif.PC_WE, 1'b0);
        5: begin
          chk("lit_lu_bubble", ex_valid, 1'b0);
          chk("lit_lu_resume", fif.PC_WE, 1'b1);
`ifdef ID_PERF_EN
          chk("lit_stall_cnt", stall_cnt, 16'd1);
`endif
        end
        6: begin chk("lit_beq_PC_Src", fif.PC_Src, 1'b1); chk("lit_beq_offset", fif.offset, 16'h0004); end
        7: begin
          chk("lit_squash_offset", fif.offset, 16'd0);
          chk("lit_squash_PC_Src", fif.PC_Src, 1'b0);
`ifdef ID_PERF_EN
          chk("lit_flush_cnt", flush_cnt, 16'd1);
`endif
        end
        8: begin chk("lit_nt_PC_Src", fif.PC_Src, 1'b0); chk("lit_nt_PC_WE", fif.PC_WE, 1'b1); end
        9: begin chk("lit_nt_ex_valid", ex_valid, 1'b1); chk("lit_nt_reg_write", ex_reg_write, 1'b0); end
        10: begin chk("lit_illegal", illegal, 1'b1); chk("lit_illegal_bubble", ex_valid, 1'b0); end
        11: begin
          chk("lit_halted", halted, 1'b1);
          chk("lit_halt_PC_WE", fif.PC_WE, 1'b0);
          chk("lit_illegal_off", illegal, 1'b0);
          chk("lit_halt_ex_op", ex_op, 6'h3F);
        end
        12: begin chk("lit_halt_bubble", ex_valid, 1'b0); chk("lit_halt_hold", halted, 1'b1); end
        default: ;
      endcase
      advance();
      @(posedge clk);
      #1;
    end

    // Async reset asserted in the middle of a load-use stall.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fif.instruction = (i < 2) ? 32'h8C220000 : 32'h00421820;
      rs_data = 32'd0;
      rt_data = 32'd0;
      @(negedge clk);
      check_cycle();
      advance();
      if (i == 3) begin
        chk("lit_midstall_PC_WE", fif.PC_WE, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("lit_areset_PC_WE", fif.PC_WE, 1'b0);
        chk("lit_areset_offset", fif.offset, 16'd0);
        chk("lit_areset_PC_Src", fif.PC_Src, 1'b0);
        chk("lit_areset_ex_valid", ex_valid, 1'b0);
        chk("lit_areset_ex_mem_read", ex_mem_read, 1'b0);
        chk("lit_areset_ex_dest", ex_dest, 5'd0);
        chk("lit_areset_rs_addr", rs_addr, 5'd0);
        chk("lit_areset_halted", halted, 1'b0);
        model_reset();
      end
      @(posedge clk);
      #1;
    end

    // Randomized episodes.
    for (int ep = 0; ep < 24; ep++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        fif.instruction = rand_instr();
        rs_data = 32'($urandom_range(0, 3));
        rt_data = ($urandom_range(0, 1) != 0) ? rs_data : 32'($urandom_range(0, 3));
        @(negedge clk);
        check_cycle();
        advance();
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
